// File: rtl/read_arbiter.sv
// Two-master (instruction/data) read arbiter in front of one shared memory port, one read in flight at a time.
// Define READ_ARBITER_RR_EN for round-robin tie-breaking; otherwise the data master always wins ties.
module read_arbiter #(
    parameter int bus_width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_raddr_valid,
    output logic                 i_raddr_ready,
    input  logic [bus_width-1:0] i_raddr,
    output logic                 i_rdata_valid,
    input  logic                 i_rdata_ready,
    output logic [bus_width-1:0] i_rdata,
    input  logic                 d_raddr_valid,
    output logic                 d_raddr_ready,
    input  logic [bus_width-1:0] d_raddr,
    output logic                 d_rdata_valid,
    input  logic                 d_rdata_ready,
    output logic [bus_width-1:0] d_rdata,
    output logic                 m_raddr_valid,
    input  logic                 m_raddr_ready,
    output logic [bus_width-1:0] m_raddr,
    input  logic                 m_rdata_valid,
    output logic                 m_rdata_ready,
    input  logic [bus_width-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;     // 1'b1 = data master owns the transaction
    logic [bus_width-1:0] addr_q,  addr_d;
    logic                 pick_d_s;

`ifdef READ_ARBITER_RR_EN
    logic                 last_q,  last_d;      // 1'b1 = data master was granted most recently

    // Tie-break toward whichever master was not served last.
    always_comb begin
        pick_d_s = 1'b0;
        if (d_raddr_valid && i_raddr_valid) begin
            pick_d_s = ~last_q;
        end else begin
            pick_d_s = d_raddr_valid;
        end
    end
`else
    // Fixed priority: data master wins ties.
    always_comb begin
        pick_d_s = 1'b0;
        if (d_raddr_valid) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
    end
`endif

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
`ifdef READ_ARBITER_RR_EN
        last_d        = last_q;
`endif
        i_raddr_ready = 1'b0;
        d_raddr_ready = 1'b0;
        i_rdata_valid = 1'b0;
        d_rdata_valid = 1'b0;
        m_raddr_valid = 1'b0;
        m_rdata_ready = 1'b0;
        m_raddr       = addr_q;
        i_rdata       = m_rdata;
        d_rdata       = m_rdata;
        case (state_q)
            IDLE: begin
                // No grant while reset is held, so nothing is accepted that would then be dropped.
                if (rst && (i_raddr_valid || d_raddr_valid)) begin
                    grant_d       = pick_d_s;
                    addr_d        = pick_d_s ? d_raddr : i_raddr;
                    d_raddr_ready = pick_d_s;
                    i_raddr_ready = ~pick_d_s;
`ifdef READ_ARBITER_RR_EN
                    last_d        = pick_d_s;
`endif
                    state_d       = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                m_raddr_valid = 1'b1;
                if (m_raddr_ready) begin
                    state_d = RESP;
                end else begin
                    state_d = ADDR;
                end
            end
            RESP: begin
                if (grant_q) begin
                    d_rdata_valid = m_rdata_valid;
                    m_rdata_ready = d_rdata_ready;
                end else begin
                    i_rdata_valid = m_rdata_valid;
                    m_rdata_ready = i_rdata_ready;
                end
                if (m_rdata_valid && m_rdata_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
            addr_q  <= {bus_width{1'b0}};
`ifdef READ_ARBITER_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
`ifdef READ_ARBITER_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// Scoreboard bench for read_arbiter: each accepted request pushes its expected address/data/owner,
// which is popped when the memory-side address phase appears and checked through the response.
module tb_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
    logic [31:0] i_raddr, i_rdata;
    logic        d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
    logic [31:0] d_raddr, d_rdata;
    logic        m_raddr_valid, m_raddr_ready, m_rdata_valid, m_rdata_ready;
    logic [31:0] m_raddr, m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    read_arbiter #(.bus_width(32)) dut (
        .clk(clk), .rst(rst),
        .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
        .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
        .d_raddr_valid(d_raddr_valid), .d_raddr_ready(d_raddr_ready), .d_raddr(d_raddr),
        .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready), .d_rdata(d_rdata),
        .m_raddr_valid(m_raddr_valid), .m_raddr_ready(m_raddr_ready), .m_raddr(m_raddr),
        .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready), .m_rdata(m_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h0000_0100) begin
            return 32'hDEAD_BEEF;
        end else begin
            return {addr[15:0], ~addr[15:0]};
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE with requests already driven; checks the grant and records the expectation.
    task automatic accept(input logic exp_d);
        exp_t e;
        #2;
        check_eq("d_raddr_ready", 32'(d_raddr_ready), 32'(exp_d));
        check_eq("i_raddr_ready", 32'(i_raddr_ready), 32'(!exp_d));
        e.is_d = exp_d;
        e.addr = exp_d ? d_raddr : i_raddr;
        e.data = mem_data(e.addr);
        sb.push_back(e);
        tick();
    endtask

    // Called one cycle after acceptance: plays the memory, with optional stalls on both phases.
    task automatic serve(input int addr_stall, input int data_stall);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty no expected transaction at %0t", $time);
            return;
        end
        e = sb.pop_front();
        m_rdata_valid = 1'b1;
        m_rdata       = 32'hBAD0_BAD0;
        for (int k = 0; k <= addr_stall; k++) begin
            m_raddr_ready = (k == addr_stall);
            #2;
            check_eq("m_raddr_valid", 32'(m_raddr_valid), 32'd1);
            check_eq("m_raddr", m_raddr, e.addr);
            check_eq("m_rdata_ready_addr", 32'(m_rdata_ready), 32'd0);
            check_eq("rdata_valid_addr", 32'({i_rdata_valid, d_rdata_valid}), 32'd0);
            check_eq("raddr_ready_busy", 32'({i_raddr_ready, d_raddr_ready}), 32'd0);
            tick();
        end
        m_raddr_ready = 1'b0;
        m_rdata       = e.data;
        for (int k = 0; k <= data_stall; k++) begin
            i_rdata_ready = !e.is_d && (k == data_stall);
            d_rdata_ready = e.is_d && (k == data_stall);
            #2;
            check_eq("m_raddr_valid_resp", 32'(m_raddr_valid), 32'd0);
            check_eq("rdata_valid", 32'({i_rdata_valid, d_rdata_valid}), 32'({!e.is_d, e.is_d}));
            check_eq("m_rdata_ready", 32'(m_rdata_ready), 32'(k == data_stall));
            check_eq("rdata", e.is_d ? d_rdata : i_rdata, e.data);
            check_eq("raddr_ready_resp", 32'({i_raddr_ready, d_raddr_ready}), 32'd0);
            tick();
        end
        m_rdata_valid = 1'b0;
        i_rdata_ready = 1'b0;
        d_rdata_ready = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        i_raddr_valid = 1'b1; i_raddr = 32'h0000_0AAA; i_rdata_ready = 1'b1;
        d_raddr_valid = 1'b1; d_raddr = 32'h0000_0BBB; d_rdata_ready = 1'b1;
        m_raddr_ready = 1'b1; m_rdata_valid = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        tick();
        #2;
        check_eq("rst_raddr_ready", 32'({i_raddr_ready, d_raddr_ready}), 32'd0);
        check_eq("rst_rdata_valid", 32'({i_rdata_valid, d_rdata_valid}), 32'd0);
        check_eq("rst_m_valid", 32'(m_raddr_valid), 32'd0);
        check_eq("rst_m_rdata_ready", 32'(m_rdata_ready), 32'd0);
        check_eq("rst_m_raddr", m_raddr, 32'd0);
        check_eq("rst_i_rdata", i_rdata, 32'h1234_5678);
        check_eq("rst_d_rdata", d_rdata, 32'h1234_5678);
        i_raddr_valid = 1'b0; d_raddr_valid = 1'b0; i_rdata_ready = 1'b0; d_rdata_ready = 1'b0;
        m_raddr_ready = 1'b0; m_rdata_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Single instruction read.
        i_raddr_valid = 1'b1; i_raddr = 32'h0000_0100;
        accept(1'b0);
        i_raddr_valid = 1'b0;
        serve(0, 0);

        // Simultaneous requests: data first, instruction keeps requesting.
        i_raddr_valid = 1'b1; i_raddr = 32'h0000_0200;
        d_raddr_valid = 1'b1; d_raddr = 32'h0000_0300;
        accept(1'b1);
        d_raddr_valid = 1'b0;
        serve(0, 0);
        accept(1'b0);
        i_raddr_valid = 1'b0;
        serve(0, 0);

        // Address and data stalls, with an instruction request pending throughout.
        d_raddr_valid = 1'b1; d_raddr = 32'h0000_0500;
        accept(1'b1);
        d_raddr_valid = 1'b0;
        i_raddr_valid = 1'b1; i_raddr = 32'h0000_0600;
        serve(3, 5);
        accept(1'b0);
        i_raddr_valid = 1'b0;
        serve(0, 0);

        // Reset during the response phase abandons the read.
        d_raddr_valid = 1'b1; d_raddr = 32'h0000_0400;
        accept(1'b1);
        d_raddr_valid = 1'b0;
        e = sb.pop_front();
        m_raddr_ready = 1'b1;
        #2;
        check_eq("abort_m_raddr", m_raddr, e.addr);
        tick();
        m_raddr_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_rdata_valid = 1'b1; m_rdata = e.data; d_rdata_ready = 1'b1;
        #2;
        check_eq("abort_rdata_valid", 32'({i_rdata_valid, d_rdata_valid}), 32'd0);
        check_eq("abort_m_rdata_ready", 32'(m_rdata_ready), 32'd0);
        check_eq("abort_m_raddr_valid", 32'(m_raddr_valid), 32'd0);
        tick();
        m_rdata_valid = 1'b0; d_rdata_ready = 1'b0;
        i_raddr_valid = 1'b1; i_raddr = 32'h0000_0700;
        accept(1'b0);
        i_raddr_valid = 1'b0;
        serve(0, 0);

        // Continuous contention after a fresh reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_raddr_valid = 1'b1; i_raddr = 32'h0000_0800;
        d_raddr_valid = 1'b1; d_raddr = 32'h0000_0900;
        for (int t = 0; t < 4; t++) begin
`ifdef READ_ARBITER_RR_EN
            accept((t % 2) == 0);
`else
            accept(1'b1);
`endif
            serve(0, 0);
        end
        i_raddr_valid = 1'b0; d_raddr_valid = 1'b0;
        tick();

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
